// File: rtl/seg7_state_monitor_pkg.sv
// Shared types and helpers for the 7-segment display-FSM monitor.
// Pure combinational functions; no state.
// No flow control; decode and next-state are used directly by the monitor.
package seg7_mon_pkg;

  // Active-low segment patterns {a,b,c,d,e,f,g} for the four displayed digits
  localparam logic [6:0] SEG_S0 = 7'b0000001;
  localparam logic [6:0] SEG_S1 = 7'b1001111;
  localparam logic [6:0] SEG_S2 = 7'b0010010;
  localparam logic [6:0] SEG_S3 = 7'b0000110;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TRANS   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  typedef enum logic [1:0] {M_UNSYNC, M_ARMED, M_WAIT} mon_t;

  typedef struct packed {
    logic   legal;
    state_t st;
  } dec_t;

  // Reference transition table of the display FSM being watched
  function automatic state_t next_state(state_t s, logic x);
    state_t n;
    unique case (s)
      S0:      n = x ? S3 : S0;
      S1:      n = x ? S2 : S0;
      S2:      n = x ? S3 : S2;
      default: n = S1;
    endcase
    return n;
  endfunction

  // Map a segment pattern back to a state code; anything else is illegal
  function automatic dec_t decode(logic [6:0] seg);
    dec_t d;
    d.legal = 1'b1;
    d.st    = S0;
    unique case (seg)
      SEG_S0:  d.st = S0;
      SEG_S1:  d.st = S1;
      SEG_S2:  d.st = S2;
      SEG_S3:  d.st = S3;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_state_monitor_if.sv
// Bundle of the observed display signals and the monitor's status outputs.
// No latency; wires only.
// No backpressure; the monitor is a passive observer.
interface seg7_state_monitor_if;
  import seg7_mon_pkg::*;

  logic [6:0]  seg;
  logic        x;
  logic        tick;
  state_t      state_o;
  logic        state_valid;
  logic        err_pulse;
  err_t        err_code;
  logic        err_sticky;
  logic [15:0] check_count;
  logic [7:0]  err_count;

  modport master (
    output seg, x, tick,
    input  state_o, state_valid, err_pulse, err_code, err_sticky, check_count, err_count
  );

  modport slave (
    input  seg, x, tick,
    output state_o, state_valid, err_pulse, err_code, err_sticky, check_count, err_count
  );
endinterface

// File: rtl/seg7_stable_filter.sv
// Debounce filter: a segment pattern is stable after STABLE_CYCLES identical samples.
// Latency STABLE_CYCLES clk from a pattern change or tick to stable.
// No backpressure; tick restarts the count so every update is re-qualified.
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       tick,
  output logic [6:0] seg_q,
  output logic       stable
);
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]    seg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Restart on any change or tick, otherwise count up and saturate
  always_comb begin
    seg_d = seg;
    cnt_d = cnt_q;
    if ((seg != seg_q) || tick) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sample register and run-length counter
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      cnt_q <= '0;
    end else begin
      seg_q <= seg_d;
      cnt_q <= cnt_d;
    end
  end

  assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg7_state_monitor.sv
// Checks displayed digits against the display FSM transition table on every tick.
// Error pulse and status registered 1 clk after detection; accept after STABLE_CYCLES.
// No backpressure; a tick during a pending check is reported as an overrun.
module seg7_state_monitor
  import seg7_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 1024
) (
  input logic clk,
  input logic rst,
  seg7_state_monitor_if.slave mon
);
  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  logic [6:0] seg_f;
  logic       stable;

  seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .seg    (mon.seg),
    .tick   (mon.tick),
    .seg_q  (seg_f),
    .stable (stable)
  );

  mon_t           mst_q, mst_d;
  state_t         prev_q, prev_d;
  state_t         state_o_q, state_o_d;
  logic           valid_q, valid_d;
  logic           x_l_q, x_l_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           ill_flag_q, ill_flag_d;
  logic [6:0]     ill_seg_q, ill_seg_d;
  logic           err_pulse_q, err_pulse_d;
  err_t           err_code_q, err_code_d;
  logic           sticky_q, sticky_d;
  logic [15:0]    chk_cnt_q, chk_cnt_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           err_det;
  err_t           err_new;
  logic           chk_inc;
  dec_t           dec;

  // Monitor FSM: sync to a legal digit, then check one transition per tick
  always_comb begin
    mst_d      = mst_q;
    prev_d     = prev_q;
    state_o_d  = state_o_q;
    valid_d    = valid_q;
    x_l_d      = x_l_q;
    wcnt_d     = wcnt_q;
    ill_flag_d = ill_flag_q;
    ill_seg_d  = ill_seg_q;
    err_det    = 1'b0;
    err_new    = ERR_NONE;
    chk_inc    = 1'b0;
    dec        = decode(seg_f);

    unique case (mst_q)
      M_UNSYNC: begin
        if (stable) begin
          if (dec.legal) begin
            prev_d     = dec.st;
            state_o_d  = dec.st;
            valid_d    = 1'b1;
            ill_flag_d = 1'b0;
            mst_d      = M_ARMED;
          end else if (!ill_flag_q || (ill_seg_q != seg_f)) begin
            // Report a held illegal pattern only once
            err_det    = 1'b1;
            err_new    = ERR_ILLEGAL;
            ill_flag_d = 1'b1;
            ill_seg_d  = seg_f;
          end
        end
      end
      M_ARMED: begin
        if (mon.tick) begin
          x_l_d  = mon.x;
          wcnt_d = '0;
          mst_d  = M_WAIT;
        end else if (stable && !dec.legal) begin
          err_det    = 1'b1;
          err_new    = ERR_ILLEGAL;
          valid_d    = 1'b0;
          ill_flag_d = 1'b1;
          ill_seg_d  = seg_f;
          mst_d      = M_UNSYNC;
        end
      end
      M_WAIT: begin
        if (mon.tick) begin
          // Overrun: the display advanced again before the last update settled
          err_det = 1'b1;
          err_new = ERR_TIMEOUT;
          x_l_d   = mon.x;
          wcnt_d  = '0;
        end else if (stable) begin
          chk_inc = 1'b1;
          if (!dec.legal) begin
            err_det    = 1'b1;
            err_new    = ERR_ILLEGAL;
            valid_d    = 1'b0;
            ill_flag_d = 1'b1;
            ill_seg_d  = seg_f;
            mst_d      = M_UNSYNC;
          end else begin
            prev_d    = dec.st;
            state_o_d = dec.st;
            mst_d     = M_ARMED;
            if (dec.st != next_state(prev_q, x_l_q)) begin
              err_det = 1'b1;
              err_new = ERR_TRANS;
            end
          end
        end else if (wcnt_q == WAIT_LAST) begin
          chk_inc    = 1'b1;
          err_det    = 1'b1;
          err_new    = ERR_TIMEOUT;
          valid_d    = 1'b0;
          ill_flag_d = 1'b0;
          mst_d      = M_UNSYNC;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: mst_d = M_UNSYNC;
    endcase
  end

  // Error reporting and statistics
  always_comb begin
    err_pulse_d = err_det;
    err_code_d  = err_code_q;
    sticky_d    = sticky_q;
    err_cnt_d   = err_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    if (err_det) begin
      err_code_d = err_new;
      sticky_d   = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (chk_inc) begin
      chk_cnt_d = chk_cnt_q + 16'd1;
    end
  end

  // State and status registers; reset aborts any pending check silently
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_q       <= M_UNSYNC;
      prev_q      <= S0;
      state_o_q   <= S0;
      valid_q     <= 1'b0;
      x_l_q       <= 1'b0;
      wcnt_q      <= '0;
      ill_flag_q  <= 1'b0;
      ill_seg_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      sticky_q    <= 1'b0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      mst_q       <= mst_d;
      prev_q      <= prev_d;
      state_o_q   <= state_o_d;
      valid_q     <= valid_d;
      x_l_q       <= x_l_d;
      wcnt_q      <= wcnt_d;
      ill_flag_q  <= ill_flag_d;
      ill_seg_q   <= ill_seg_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      sticky_q    <= sticky_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mon.state_o     = state_o_q;
  assign mon.state_valid = valid_q;
  assign mon.err_pulse   = err_pulse_q;
  assign mon.err_code    = err_code_q;
  assign mon.err_sticky  = sticky_q;
  assign mon.check_count = chk_cnt_q;
  assign mon.err_count   = err_cnt_q;

endmodule

// File: tb/tb_seg7_state_monitor.sv
// Bench for seg7_state_monitor with STABLE_CYCLES=4, TIMEOUT=32.
// Transition vectors go through a scoreboard queue; corner cases are hand sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seg7_state_monitor;
  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] PX = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_state_monitor_if mif();

  seg7_state_monitor #(.STABLE_CYCLES(4), .TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_chk = 0;
  int exp_err = 0;

  typedef struct {
    logic       x;
    logic [6:0] seg;
    int         st;
    int         code;
    int         err;
  } vec_t;

  vec_t vecs[13];
  vec_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] toggle(input logic [6:0] s);
    return (s == P0) ? P1 : P0;
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Tick the display, present the new digit, wait for the check, compare with queue head
  task automatic apply_vec(input vec_t v);
    int   c0;
    int   pulses;
    bit   got;
    vec_t e;
    sbq.push_back(v);
    c0 = int'(mif.check_count);
    mif.x    = v.x;
    mif.tick = 1'b1;
    @(negedge clk);
    mif.tick = 1'b0;
    mif.seg  = v.seg;
    pulses   = 0;
    got      = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (mif.err_pulse) pulses++;
      if (int'(mif.check_count) != c0) got = 1'b1;
    end
    e = sbq.pop_front();
    if (!got) begin
      chk("vec_check_done", 0, 1);
    end else begin
      exp_chk++;
      exp_err = sat8(exp_err + e.err);
      chk("vec_state_o", int'(mif.state_o), e.st);
      chk("vec_state_valid", int'(mif.state_valid), 1);
      chk("vec_err_code", int'(mif.err_code), e.code);
      chk("vec_check_count", int'(mif.check_count), exp_chk);
      chk("vec_err_count", int'(mif.err_count), exp_err);
      repeat (2) begin
        @(negedge clk);
        if (mif.err_pulse) pulses++;
      end
      chk("vec_err_pulses", pulses, e.err);
    end
  endtask

  initial begin
    int   pulses;
    int   pidx;
    int   c0;
    bit   got;

    vecs[0]  = '{1'b1, P3, 3, 0, 0};
    vecs[1]  = '{1'b1, P1, 1, 0, 0};
    vecs[2]  = '{1'b1, P0, 0, 2, 1};
    vecs[3]  = '{1'b0, P0, 0, 2, 0};
    vecs[4]  = '{1'b1, P3, 3, 2, 0};
    vecs[5]  = '{1'b0, P1, 1, 2, 0};
    vecs[6]  = '{1'b0, P0, 0, 2, 0};
    vecs[7]  = '{1'b1, P3, 3, 2, 0};
    vecs[8]  = '{1'b1, P1, 1, 2, 0};
    vecs[9]  = '{1'b1, P2, 2, 2, 0};
    vecs[10] = '{1'b0, P2, 2, 2, 0};
    vecs[11] = '{1'b1, P3, 3, 2, 0};
    vecs[12] = '{1'b1, P2, 2, 2, 1};

    // Reset state
    rst      = 1'b1;
    mif.seg  = P0;
    mif.x    = 1'b0;
    mif.tick = 1'b0;
    step(3);
    chk("rst_state_o", int'(mif.state_o), 0);
    chk("rst_state_valid", int'(mif.state_valid), 0);
    chk("rst_err_pulse", int'(mif.err_pulse), 0);
    chk("rst_err_code", int'(mif.err_code), 0);
    chk("rst_err_sticky", int'(mif.err_sticky), 0);
    chk("rst_check_count", int'(mif.check_count), 0);
    chk("rst_err_count", int'(mif.err_count), 0);

    // Initial sync on a held S0 digit
    rst = 1'b0;
    step(6);
    chk("sync_state_valid", int'(mif.state_valid), 1);
    chk("sync_state_o", int'(mif.state_o), 0);
    chk("sync_err_sticky", int'(mif.err_sticky), 0);
    chk("sync_check_count", int'(mif.check_count), 0);
    chk("sync_err_count", int'(mif.err_count), 0);

    // Transition vectors (passes, wrong transitions, unchanged digits)
    for (int i = 0; i < 13; i++) begin
      apply_vec(vecs[i]);
      if (i == 2) chk("trans_err_sticky", int'(mif.err_sticky), 1);
    end

    // Held illegal pattern: one error, sync lost, then resync on a legal digit
    mif.seg = PX;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mif.err_pulse) pulses++;
    end
    exp_err = sat8(exp_err + 1);
    chk("ill_pulses", pulses, 1);
    chk("ill_err_code", int'(mif.err_code), 1);
    chk("ill_state_valid", int'(mif.state_valid), 0);
    chk("ill_err_count", int'(mif.err_count), exp_err);
    chk("ill_check_count", int'(mif.check_count), exp_chk);
    mif.seg = P2;
    step(8);
    chk("ill_resync_valid", int'(mif.state_valid), 1);
    chk("ill_resync_state", int'(mif.state_o), 2);

    // Timeout: seg keeps toggling so nothing is ever accepted
    mif.x    = 1'b0;
    mif.tick = 1'b1;
    pulses   = 0;
    pidx     = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) mif.tick = 1'b0;
      if (mif.err_pulse) begin
        pulses++;
        if (pidx < 0) pidx = i;
      end
      if (i % 2 == 0) mif.seg = toggle(mif.seg);
    end
    exp_chk++;
    exp_err = sat8(exp_err + 1);
    chk("to_pulses", pulses, 1);
    chk("to_pulse_cycle", pidx, 32);
    chk("to_err_code", int'(mif.err_code), 3);
    chk("to_state_valid", int'(mif.state_valid), 0);
    chk("to_check_count", int'(mif.check_count), exp_chk);
    chk("to_err_count", int'(mif.err_count), exp_err);
    mif.seg = P0;
    step(8);
    chk("to_resync_valid", int'(mif.state_valid), 1);
    chk("to_resync_state", int'(mif.state_o), 0);

    // Overrun: second tick before the first update settles; check then completes
    mif.x    = 1'b1;
    mif.tick = 1'b1;
    pulses   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) mif.tick = 1'b0;
      if (mif.err_pulse) pulses++;
      if (i % 2 == 1) mif.seg = toggle(mif.seg);
    end
    chk("ovr_pre_pulses", pulses, 0);
    c0       = int'(mif.check_count);
    mif.x    = 1'b1;
    mif.tick = 1'b1;
    @(negedge clk);
    mif.tick = 1'b0;
    mif.seg  = P3;
    pulses   = 0;
    got      = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (mif.err_pulse) pulses++;
      if (int'(mif.check_count) != c0) got = 1'b1;
      else @(negedge clk);
    end
    chk("ovr_check_done", int'(got), 1);
    exp_chk++;
    exp_err = sat8(exp_err + 1);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_err_code", int'(mif.err_code), 3);
    chk("ovr_state_o", int'(mif.state_o), 3);
    chk("ovr_state_valid", int'(mif.state_valid), 1);
    chk("ovr_check_count", int'(mif.check_count), exp_chk);
    chk("ovr_err_count", int'(mif.err_count), exp_err);
    step(2);

    // Error counter saturation: tick held high gives one overrun per cycle
    mif.x    = 1'b0;
    mif.tick = 1'b1;
    step(151);
    chk("sat_mid_err_count", int'(mif.err_count), sat8(exp_err + 150));
    step(150);
    mif.tick = 1'b0;
    mif.seg  = P1;
    exp_err  = sat8(exp_err + 300);
    c0       = int'(mif.check_count);
    got      = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (int'(mif.check_count) != c0) got = 1'b1;
    end
    exp_chk++;
    chk("sat_check_done", int'(got), 1);
    chk("sat_err_count", int'(mif.err_count), 255);
    chk("sat_state_o", int'(mif.state_o), 1);
    chk("sat_err_code", int'(mif.err_code), 3);
    chk("sat_check_count", int'(mif.check_count), exp_chk);

    // Reset during a pending check: no error, everything cleared
    mif.x    = 1'b1;
    mif.tick = 1'b1;
    @(negedge clk);
    mif.tick = 1'b0;
    mif.seg  = P2;
    step(2);
    rst = 1'b1;
    step(2);
    chk("mid_rst_err_pulse", int'(mif.err_pulse), 0);
    chk("mid_rst_err_count", int'(mif.err_count), 0);
    chk("mid_rst_check_count", int'(mif.check_count), 0);
    chk("mid_rst_state_valid", int'(mif.state_valid), 0);
    chk("mid_rst_err_sticky", int'(mif.err_sticky), 0);
    rst = 1'b0;
    step(8);
    chk("post_rst_state_o", int'(mif.state_o), 2);
    chk("post_rst_err_count", int'(mif.err_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
